// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter that merges two address fifos onto one memory read port
// and routes in-order read returns back to the requester that issued them.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH           = 16,
    parameter int MEM_DATA_WIDTH_BYTES = 32,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             a_fifo_addr,
    input  logic                              a_fifo_empty,
    output logic                              a_fifo_pop,
    input  logic [ADDR_WIDTH-1:0]             b_fifo_addr,
    input  logic                              b_fifo_empty,
    output logic                              b_fifo_pop,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic                              mem_gnt,
    input  logic                              mem_rvalid,
    input  logic [8*MEM_DATA_WIDTH_BYTES-1:0] mem_rdata,
    output logic                              a_valid_data,
    output logic [8*MEM_DATA_WIDTH_BYTES-1:0] a_data,
    output logic                              b_valid_data,
    output logic [8*MEM_DATA_WIDTH_BYTES-1:0] b_data,
    output logic                              busy,
    output logic                              rsp_error
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   outstanding;
    logic                   prio;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_WIDTH-1:0]   tag_wr_ptr;
    logic [PTR_WIDTH-1:0]   tag_rd_ptr;

    logic a_elig;
    logic b_elig;
    logic capture;
    logic winner;
    logic rsp_accept;
    logic rsp_tag;

    // A new request may be captured whenever the port is free or is being
    // granted this cycle, so back-to-back grants sustain one read per cycle.
    always_comb begin
        a_elig     = ~a_fifo_empty;
        b_elig     = ~b_fifo_empty;
        capture    = (outstanding < MAX_CNT) && (a_elig || b_elig) &&
                     ((state == IDLE) || mem_gnt);
        winner     = (a_elig && b_elig) ? prio : b_elig;
        rsp_accept = mem_rvalid && (outstanding != '0);
        rsp_tag    = tag_mem[tag_rd_ptr];
    end

    assign a_fifo_pop = capture & ~winner;
    assign b_fifo_pop = capture & winner;
    assign mem_req    = (state == REQ);
    assign busy       = (state == REQ) || (outstanding != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mem_addr <= '0;
            prio     <= 1'b0;
        end else if (capture) begin
            state    <= REQ;
            mem_addr <= winner ? b_fifo_addr : a_fifo_addr;
            prio     <= ~winner;
        end else if ((state == REQ) && mem_gnt) begin
            state    <= IDLE;
        end
    end

    // Slots are reserved at capture, not at grant, so the tag queue can never
    // hold more entries than reads that will eventually return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            tag_mem     <= '0;
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
        end else begin
            if (capture) begin
                tag_mem[tag_wr_ptr] <= winner;
                tag_wr_ptr          <= tag_wr_ptr + PTR_WIDTH'(1);
            end
            if (rsp_accept) begin
                tag_rd_ptr <= tag_rd_ptr + PTR_WIDTH'(1);
            end
            case ({capture, rsp_accept})
                2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
                2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_data <= 1'b0;
            b_valid_data <= 1'b0;
            a_data       <= '0;
            b_data       <= '0;
            rsp_error    <= 1'b0;
        end else begin
            a_valid_data <= 1'b0;
            b_valid_data <= 1'b0;
            if (rsp_accept) begin
                if (rsp_tag) begin
                    b_valid_data <= 1'b1;
                    b_data       <= mem_rdata;
                end else begin
                    a_valid_data <= 1'b1;
                    a_data       <= mem_rdata;
                end
            end
            if (mem_rvalid && (outstanding == '0)) begin
                rsp_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of memory word address.
REQ-002 Parameter MEM_DATA_WIDTH_BYTES, default 32, memory read data width in bytes.
REQ-003 Parameter MAX_OUTSTANDING, default 4, power of two ≥2, max reads in flight.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a_fifo_addr  input  ADDR_WIDTH  head address of A address fifo.
REQ-007 a_fifo_empty  input  1  A address fifo empty.
REQ-008 a_fifo_pop  output  1  pop A address fifo this cycle.
REQ-009 b_fifo_addr / b_fifo_empty / b_fifo_pop  same as REQ-006..008 for B.
REQ-010 mem_req  output  1  read request to memory port.
REQ-011 mem_addr  output  ADDR_WIDTH  read address, valid while mem_req.
REQ-012 mem_gnt  input  1  memory accepts request when mem_req & mem_gnt.
REQ-013 mem_rvalid  input  1  read data valid; returns in grant order.
REQ-014 mem_rdata  input  8*MEM_DATA_WIDTH_BYTES  read data.
REQ-015 a_valid_data / a_data  output  1 / 8*MEM_DATA_WIDTH_BYTES  data routed to A buffer.
REQ-016 b_valid_data / b_data  output  1 / 8*MEM_DATA_WIDTH_BYTES  data routed to B buffer.
REQ-017 busy  output  1  request pending or reads outstanding.
REQ-018 rsp_error  output  1  sticky: mem_rvalid received with no read outstanding.

Function
REQ-019 States: IDLE (mem_req=0) and REQ (mem_req=1, mem_addr held stable until grant).
REQ-020 Requester A eligible when ~a_fifo_empty; B likewise; capture allowed when outstanding < MAX_OUTSTANDING.
REQ-021 Capture occurs when capture allowed, ≥1 requester eligible, and (state==IDLE or mem_req & mem_gnt).
REQ-022 On capture: winner head address registered into mem_addr, winner fifo popped for exactly that cycle, 1-bit tag (0=A,1=B) pushed to tag queue, outstanding incremented, next state REQ.
REQ-023 On mem_req & mem_gnt without capture: next state IDLE; back-to-back grants sustain one request per cycle.
REQ-024 Arbitration round-robin: 1-bit priority pointer, reset to A; after a capture pointer points to the non-winner; a sole eligible requester always wins.
REQ-025 Outstanding counter, width $clog2(MAX_OUTSTANDING)+1, counts captured-not-yet-returned reads; captured request reserves its slot before grant.
REQ-026 Simultaneous capture and mem_rvalid: counter unchanged net; tag push and pop both performed.
REQ-027 Tag queue depth MAX_OUTSTANDING, pointer wrap-around modulo depth; never overflows by REQ-020.
REQ-028 On mem_rvalid with outstanding>0: pop tag; one cycle later assert a_valid_data (tag 0) or b_valid_data (tag 1) for one cycle with registered mem_rdata on the matching data output.
REQ-029 Only one of a_valid_data/b_valid_data asserted per cycle; data outputs hold last value otherwise.
REQ-030 On mem_rvalid with outstanding==0: data dropped, no valid output, counter unchanged, rsp_error set until reset.
REQ-031 busy = (state==REQ) | (outstanding != 0).
REQ-032 Fifo pops never issued on an empty fifo.

Reset
REQ-033 reset asserted, at any time incl. mid-transaction: state IDLE, mem_req=0, mem_addr=0, pops=0, outstanding=0, tag queue empty, pointer=A, a/b_valid_data=0, a/b_data=0, rsp_error=0, busy=0; in-flight returns after release are treated per REQ-030.

Verification
REQ-034 A fifo holds 0x0010, B empty, mem_gnt=1 -> a_fifo_pop 1 cycle, mem_req with mem_addr=0x0010 next cycle, granted, state IDLE.
REQ-035 Both fifos nonempty continuously, mem_gnt=1 -> captures alternate A,B,A,B; one request per cycle until outstanding reaches 4, then mem_req drops.
REQ-036 mem_gnt=0 for 5 cycles with mem_req=1 -> mem_addr stable, no pops, raised grant completes it.
REQ-037 Issue A,B,B then return 3 rvalids with data 0x11,0x22,0x33 -> a_valid_data with 0x11, then b_valid_data with 0x22, 0x33, each 1 cycle after rvalid.
REQ-038 mem_rvalid with nothing outstanding -> no valid output, rsp_error=1 until reset.
REQ-039 reset pulsed with 3 reads outstanding -> all outputs to REQ-033 values next edge, busy=0.
